// File: rtl/mips_reg_dump.sv
// mips_reg_dump: after the core halts, walks the register file and streams {index, value}
// beats over valid/ready while building an XOR checksum of every value sent.
module mips_reg_dump #(
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              halted,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d, acc_q, acc_d;
  logic              halted_q, is_last;
  assign is_last = idx_q == LAST;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        idx_d   = '0;
        acc_d   = '0;
        state_d = halted && !halted_q ? FETCH : IDLE;
      end
      FETCH: begin
        data_d  = rf_rdata;
        state_d = SEND;
      end
      SEND: if (dump_ready) begin
        acc_d   = acc_q ^ data_q;
        state_d = is_last ? DONE : FETCH;
        idx_d   = is_last ? idx_q : idx_q + 1'b1;
      end
      DONE: state_d = halted ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      data_q   <= '0;
      acc_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      acc_q    <= acc_d;
      halted_q <= halted;
    end
  end
  // Beat fields are forced to zero whenever no beat is being offered.
  assign rf_raddr   = idx_q;
  assign dump_valid = state_q == SEND;
  assign dump_index = dump_valid ? idx_q : '0;
  assign dump_data  = dump_valid ? data_q : '0;
  assign dump_last  = dump_valid && is_last;
  assign busy       = state_q == FETCH || state_q == SEND;
  assign done       = state_q == DONE;
  assign checksum   = done ? acc_q : '0;
endmodule

// File: tb/tb_mips_reg_dump.sv
// tb_mips_reg_dump: scoreboarded bench for the register dump engine (32-reg and 4-reg instances).
module tb_mips_reg_dump;
  logic        clk1 = 1'b0;
  logic        rst_n, halted, dump_ready;
  logic [4:0]  rf_raddr, dump_index;
  logic [31:0] rf_rdata, dump_data, checksum;
  logic        dump_valid, dump_last, busy, done;
  logic [31:0] rf [32];
  logic        halted4;
  logic [1:0]  rf_raddr4, dump_index4;
  logic [31:0] rf_rdata4, dump_data4, checksum4;
  logic        dump_valid4, dump_last4, busy4, done4;
  logic [31:0] rf4 [4];
  int total = 0, passed = 0, cyc = 0, start_cyc = 0, start4 = 0;
  logic [37:0] exp_q[$], held;
  logic [34:0] q4[$];
  logic [31:0] exp_sum[$];
  int          exp_lat[$];
  logic        stall_prev = 1'b0, done_prev = 1'b0;

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;
  assign rf_rdata  = rf[rf_raddr];
  assign rf_rdata4 = rf4[rf_raddr4];

  mips_reg_dump dut (
    .clk1(clk1), .rst_n(rst_n), .halted(halted), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_index(dump_index),
    .dump_data(dump_data), .dump_last(dump_last), .busy(busy), .done(done), .checksum(checksum)
  );
  mips_reg_dump #(.NREGS(4), .ADDR_W(2), .DATA_W(32)) dut4 (
    .clk1(clk1), .rst_n(rst_n), .halted(halted4), .rf_raddr(rf_raddr4), .rf_rdata(rf_rdata4),
    .dump_valid(dump_valid4), .dump_ready(1'b1), .dump_index(dump_index4),
    .dump_data(dump_data4), .dump_last(dump_last4), .busy(busy4), .done(done4), .checksum(checksum4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic miss(input string nm);
    total++;
    $display("FAIL %s: got nothing expected event", nm);
  endtask

  // Monitor: pops on every handshake, checks stalls hold steady and done arrives on time.
  always @(negedge clk1) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      done_prev  = 1'b0;
    end else begin
      if (dump_valid) begin
        if (stall_prev) chk("stall_hold", {dump_index, dump_data, dump_last}, held);
        if (dump_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_beat: got idx %0d data %h expected no beat", dump_index, dump_data);
          end else chk("beat", {dump_index, dump_data, dump_last}, exp_q.pop_front());
        end
        held       = {dump_index, dump_data, dump_last};
        stall_prev = !dump_ready;
      end else begin
        if (stall_prev) chk("valid_dropped", 0, 1);
        stall_prev = 1'b0;
      end
      if (done && !done_prev) begin
        if (exp_sum.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: got done expected none");
        end else begin
          chk("checksum", checksum, exp_sum.pop_front());
          chk("done_latency", cyc - start_cyc, exp_lat.pop_front());
        end
      end
      done_prev = done;
    end
    if (rst_n && dump_valid4) begin
      if (q4.size() == 0) miss("beat4_expected");
      else chk("beat4", {dump_index4, dump_data4, dump_last4}, q4.pop_front());
    end
  end

  task automatic push_dump(input logic [31:0] sum, input int lat);
    for (int i = 0; i < 32; i++) exp_q.push_back({5'(i), rf[i], i == 31});
    exp_sum.push_back(sum);
    exp_lat.push_back(lat);
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic start();
    start_cyc = cyc + 1;
    halted    = 1'b1;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!done && n < lim) begin
      @(negedge clk1);
      n++;
    end
    if (!done) miss("done_timeout");
  endtask

  task automatic wait_beat(input logic [4:0] idx, input int lim);
    int n = 0;
    do begin
      @(negedge clk1);
      n++;
    end while (!(dump_valid && dump_index == idx) && n < lim);
    if (!(dump_valid && dump_index == idx)) miss("beat_timeout");
  endtask

  initial begin
    int busy_cnt;
    foreach (rf[i]) rf[i] = '0;
    rf[1] = 32'hAA; rf[2] = 32'h55; rf[3] = 32'hFF;
    rf4[0] = 32'h1; rf4[1] = 32'h2; rf4[2] = 32'h4; rf4[3] = 32'h8;
    rst_n = 1'b0; halted = 1'b0; halted4 = 1'b0; dump_ready = 1'b1;
    #1;
    chk("reset_outputs", {rf_raddr, dump_valid, dump_index, dump_data, dump_last, busy, done, checksum}, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    // Basic dump
    push_dump(32'h0, 64);
    start();
    wait_done(80);
    step(); halted = 1'b0; step(); step();
    // Backpressure on index 2
    push_dump(32'h0, 69);
    start();
    wait_beat(5'd1, 20);
    step(); dump_ready = 1'b0;
    step();
    repeat (5) @(posedge clk1);
    #1 dump_ready = 1'b1;
    wait_done(80);
    step(); halted = 1'b0; step(); step();
    // Reset while index 10 is valid
    push_dump(32'h0, 64);
    start();
    wait_beat(5'd10, 40);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {rf_raddr, dump_valid, dump_index, dump_data, dump_last, busy, done, checksum}, 0);
    exp_q.delete(); exp_sum.delete(); exp_lat.delete();
    step();
    push_dump(32'h0, 64);
    start_cyc = cyc + 1;
    rst_n = 1'b1;
    wait_done(80);
    step(); halted = 1'b0; step(); step();
    // Halt falls at index 5
    push_dump(32'h0, 64);
    start();
    wait_beat(5'd5, 20);
    step(); halted = 1'b0;
    wait_done(80);
    chk("done_pulse_hi", done, 1);
    @(negedge clk1);
    chk("done_pulse_lo", {done, busy, dump_valid}, 0);
    step(); step();
    // Single-shot with a nonzero checksum
    rf[5] = 32'h12345678; rf[31] = 32'h80000001;
    push_dump(32'h92345679, 64);
    start();
    wait_done(80);
    busy_cnt = 0;
    repeat (200) begin
      @(negedge clk1);
      if (busy || dump_valid || !done) busy_cnt++;
    end
    chk("no_retrigger", busy_cnt, 0);
    step(); halted = 1'b0; step(); step();
    push_dump(32'h92345679, 64);
    start();
    wait_done(80);
    step(); halted = 1'b0; step(); step();
    chk("queue_drained", exp_q.size() + exp_sum.size(), 0);
    // Four-register instance
    for (int i = 0; i < 4; i++) q4.push_back({2'(i), rf4[i], i == 3});
    start4 = cyc + 1;
    halted4 = 1'b1;
    begin
      int n = 0;
      while (!done4 && n < 30) begin
        @(negedge clk1);
        n++;
      end
    end
    chk("done4", done4, 1);
    chk("checksum4", checksum4, 32'h0000000F);
    chk("done4_latency", cyc - start4, 8);
    chk("queue4_drained", q4.size(), 0);
    step(); halted4 = 1'b0; step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mips_reg_dump.md
# mips_reg_dump

Post-halt register-file readout engine for the pipelined MIPS core. When the core's halt flag rises, the block walks the register file from index 0 to NREGS-1 through a single combinational read port. It streams each {index, value} pair out over a valid/ready interface and accumulates an XOR checksum of all values. It turns the register file into a self-describing output stream, so benches and debug hosts no longer need hierarchical access to the register array.

## Interface
- NREGS, 32, number of registers dumped (2..2**ADDR_W)
- ADDR_W, 5, register index width
- DATA_W, 32, register data width

- clk1  in  1  processor phase-1 clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- halted  in  1  core halt flag (halted_out of the core), level
- rf_raddr  out  ADDR_W  register-file read address
- rf_rdata  in  DATA_W  register-file read data, combinational from rf_raddr
- dump_valid  out  1  stream beat valid
- dump_ready  in  1  stream sink ready
- dump_index  out  ADDR_W  register index of current beat
- dump_data  out  DATA_W  register value of current beat
- dump_last  out  1  high with the beat for index NREGS-1
- busy  out  1  dump in progress (state FETCH or SEND)
- done  out  1  dump complete; checksum valid
- checksum  out  DATA_W  XOR of all dumped values

## Operation
- Rising-edge detect: halted_q registers halted and resets to 0. A start condition is halted=1 && halted_q=0 while in IDLE. If halted is already 1 when reset releases, that counts as a start.
- FSM states: IDLE, FETCH, SEND, DONE.
  - IDLE: idx=0, accumulator=0. On start, go to FETCH.
  - FETCH: rf_raddr=idx. On the next edge, capture rf_rdata into data_q and go to SEND.
  - SEND: dump_valid=1. dump_index=idx, dump_data=data_q, dump_last=(idx==NREGS-1).
    - Handshake is dump_valid && dump_ready on a clk1 edge. On handshake, acc ^= data_q.
    - After the handshake, go to DONE if idx==NREGS-1; otherwise idx+1 and go to FETCH.
    - Without a handshake, all beat outputs hold stable and the state stays SEND.
  - DONE: done=1 and checksum=acc, held. Return to IDLE on the first edge with halted=0. The minimum DONE duration is one cycle.
- checksum reads 0 outside DONE.
- The dump is not re-triggered while halted stays high; a new dump requires halted to fall and rise again.
- If halted falls mid-dump, it is ignored and the dump completes all NREGS beats.
- idx never wraps: the counter stops at NREGS-1. Widths: idx is ADDR_W bits, and the XOR is bitwise over DATA_W.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, idx=0, rf_raddr=0, dump_valid=0, dump_index=0, dump_data=0, dump_last=0, busy=0, done=0, checksum=0, acc=0, halted_q=0.
- Reset mid-dump aborts with no partial done. Any beat in flight is dropped.
- Start is sampled at edge E0. FETCH occupies E0→E1, and dump_valid first goes high after E1.
- With dump_ready tied to 1, each register costs 2 cycles (FETCH + SEND). The last handshake occurs at edge E0+2·NREGS, and done rises after that edge.
- Throughput is 1 beat per 2 cycles maximum. Each cycle dump_ready is low adds exactly 1 cycle.
- rf_raddr is stable for the whole FETCH cycle, and rf_rdata is sampled only at the end of FETCH.
- dump_valid never drops without a handshake, and it is never asserted in IDLE or DONE.

## Test plan
- **Basic dump:** Reg1=0xAA, Reg2=0x55, Reg3=0xFF, other registers 0; dump_ready=1; raise halted.
  - 32 beats with indices 0..31 in order, and beat 3 data=0x000000FF.
  - dump_last only on index 31.
  - done rises 64 cycles after start with checksum=0x00000000.
- **Backpressure:** as the basic dump, but hold dump_ready=0 for 5 cycles while index 2 is valid.
  - index=2 and data=0x55 stay stable throughout.
  - No beat is skipped or duplicated, and done arrives 5 cycles later (69).
- **Reset mid-dump:** assert rst_n=0 while index 10 is valid, keeping halted=1.
  - All outputs go 0 immediately.
  - After release, the dump restarts at index 0 and completes with the correct checksum.
- **Halt drops mid-dump:** halted falls at index 5.
  - The dump finishes all 32 beats.
  - done is high for exactly 1 cycle, then the FSM returns to IDLE.
- **Single-shot:** keep halted=1 for 200 cycles after done.
  - No second dump occurs.
  - Lowering halted then raising it again produces exactly one new dump.
- **Parameter variant:** NREGS=4 with values 0x1, 0x2, 0x4, 0x8.
  - 4 beats, with dump_last on index 3.
  - checksum=0x0000000F.
